regencode: RTL
==============

# regencode

Register-address encoder for the R.O.E datapath: the sending side of the page-header scheme that `regdecode` consumes. It accepts full 4-bit register addresses and emits the `set_pa`/`instr` pair each instruction slot needs. It tracks the page header (address bits [3:2]) the decoder currently holds and asserts the page-write enable only when the header must change. It sits between the instruction-assembly path and the decode stage, with a small request FIFO and valid/ready handshakes on both sides.

## Interface
- `DEPTH`, 4: request FIFO entries (power of two, ≥2).
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `flush` input 1: invalidates the tracked header and empties the FIFO.
- `req_valid` input 1: a request is presented.
- `req_addr` input 4: full register address {page[1:0], reg[1:0]}.
- `req_ready` output 1: FIFO not full.
- `out_valid` output 1: an encoded beat is presented.
- `out_ready` input 1: downstream accepts the beat.
- `set_pa` output 3: {page-write enable, page[1:0]}.
- `instr` output 2: low register bits.

## Operation
- A request is accepted on `req_valid && req_ready` and pushed into the FIFO.
- State: `hdr_q[1:0]` is the header the decoder holds. `hdr_known` is cleared by reset and by flush, and set after any accepted beat that carried the page-write enable.
- The head entry drives the output combinationally from FIFO/state registers: `instr = addr[1:0]`.
  - `switch = !hdr_known || addr[3:2] != hdr_q`.
  - `set_pa = {switch, switch ? addr[3:2] : 2'b00}`.
- On `out_valid && out_ready`:
  - pop the FIFO;
  - if `switch`, set `hdr_q <= addr[3:2]` and `hdr_known <= 1`.
- When `out_valid` is 0, `set_pa` and `instr` are 0, so an idle decoder never rewrites its header.
- Header is one beat: the decoder writes the page and the low bits in the same cycle. There is no separate set-page beat.
- Full FIFO:
  - `req_ready` is 0.
  - A pop and a push in the same cycle are both allowed. `req_ready` depends only on the registered count, never on `out_ready`.
- Empty FIFO: `out_valid` is 0. There is no bypass, so a push becomes visible the next cycle.
- Flush:
  - count is reset to 0 and `hdr_known` to 0;
  - a same-cycle push is dropped;
  - a same-cycle accepted beat has no effect on `hdr_q`.
- Pointers wrap modulo `DEPTH`. The count is `$clog2(DEPTH)+1` bits wide.

## Timing
- Reset values: `req_ready`=1, `out_valid`=0, `set_pa`=0, `instr`=0, `hdr_q`=0, `hdr_known`=0, FIFO empty.
- Latency is 1 cycle from request accept to `out_valid` with an empty FIFO.
- Throughput is one beat per cycle, sustained.
- Reset mid-stream discards every queued entry on the next edge. The output is 0 in the first cycle after reset.
- Output handshake rule: while `out_valid` is 1 and `out_ready` is 0, `set_pa`/`instr` hold stable.

## Configuration
- `REGENC_STATS_EN`:
  - When defined, adds output `page_switches[15:0]`. It increments on every accepted beat with `set_pa[2]=1`, saturates at 16'hFFFF, and is cleared by reset only (flush does not clear it).
  - When undefined, the port and counter are absent and behaviour is otherwise identical.

## Structure
- Shared package `roe_pkg`:
  - `reg_addr_t` (4 bits);
  - `page_t` (2 bits);
  - `PAGE_EN_BIT` = 2.
- Sub-module `regenc_fifo`: a parameterised sync FIFO with push/pop/flush and full/empty outputs. `regencode` adds the header tracking and the output encoding around it.

## Test plan
- Reset, then push 4'hB → next cycle `out_valid`=1, `set_pa`=3'b110, `instr`=2'b11. Accept it → `hdr_q`=2'b10.
- After that, push 4'h9 → `set_pa`=3'b000, `instr`=2'b01. A model `regdecode` yields reg_addr 4'h9.
- Push 4'h2, 4'h3, 4'hE back-to-back with `out_ready`=1 → beats {110,10}? No: with header 2'b10 the beats are `set_pa`=3'b100,`instr`=2'b10; then 3'b000/2'b11; then 3'b111/2'b10.
- Hold `out_ready`=0 while pushing DEPTH+1 requests → `req_ready` drops after the 4th push, the 5th is not accepted, and the output holds stable.
- Assert `flush` with 3 queued entries → `out_valid`=0 next cycle. The next push of the last header's page still emits `set_pa[2]`=1.
- With `REGENC_STATS_EN`, run 3 switch beats and 2 non-switch beats → `page_switches`=3. Reset → 0.

Source files
------------

// File: rtl/roe_pkg.sv
// Shared types for the R.O.E register-address path.
//   reg_addr_t  : full 4-bit register address {page[1:0], reg[1:0]}
//   page_t      : 2-bit page header held by the decoder
//   PAGE_EN_BIT : position of the page-write enable inside set_pa
package roe_pkg;
  typedef logic [3:0] reg_addr_t;
  typedef logic [1:0] page_t;

  localparam int PAGE_EN_BIT = 2;

  function automatic page_t addr_page(input reg_addr_t addr);
    return addr[3:2];
  endfunction
endpackage

// File: rtl/regencode_if.sv
// Bus bundle between the instruction-assembly path, regencode and the
// decode stage.
//   req_valid/req_addr/req_ready : request side (master drives valid/addr)
//   out_valid/set_pa/instr       : encoded beat toward the decoder
//   out_ready                    : decoder accepts the beat
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. Once valid is raised the payload holds stable until the transfer;
// ready may be given independently of valid.
interface regencode_if;
  import roe_pkg::*;

  logic      req_valid;
  reg_addr_t req_addr;
  logic      req_ready;
  logic      out_valid;
  logic      out_ready;
  logic [2:0] set_pa;
  logic [1:0] instr;

  modport master (
    output req_valid, req_addr, out_ready,
    input  req_ready, out_valid, set_pa, instr
  );

  modport slave (
    input  req_valid, req_addr, out_ready,
    output req_ready, out_valid, set_pa, instr
  );
endinterface

// File: rtl/regenc_fifo.sv
// Small synchronous FIFO used as the regencode request queue.
//   clk, reset : clock, synchronous active-high reset
//   flush      : empties the FIFO; a same-cycle push is dropped
//   push, pop  : write / read strobes (ignored when full / empty)
//   wdata      : data written on push
//   rdata      : head entry (valid while !empty)
//   full, empty: derived from the registered count only
module regenc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/regencode.sv
// Register-address encoder: turns full 4-bit register addresses into the
// {set_pa, instr} pair the page-header decoder consumes, asserting the
// page-write enable only when the decoder's header must change.
//   clk, reset    : clock, synchronous active-high reset
//   flush         : forget the tracked header and empty the request FIFO
//   bus (slave)   : request in (req_*), encoded beat out (out_*, set_pa, instr)
//   page_switches : (only with REGENC_STATS_EN) saturating count of accepted
//                   beats that carried the page-write enable; reset clears it,
//                   flush does not
// Optional feature macro: REGENC_STATS_EN.
module regencode
  import roe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  regencode_if.slave   bus
`ifdef REGENC_STATS_EN
  ,
  output logic [15:0]  page_switches
`endif
);
  reg_addr_t head;
  logic      full;
  logic      empty;
  logic      push;
  logic      fire;
  logic      switch;
  page_t     head_page;
  page_t     hdr_q;
  logic      hdr_known;

  assign push = bus.req_valid && bus.req_ready;
  assign fire = bus.out_valid && bus.out_ready;

  regenc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(reg_addr_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (fire),
    .wdata (bus.req_addr),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.req_ready = !full;
  assign bus.out_valid = !empty;

  assign head_page = addr_page(head);
  assign switch    = !hdr_known || (head_page != hdr_q);

  // Idle output is all-zero so the decoder never rewrites its header when
  // nothing is presented.
  always_comb begin
    bus.set_pa = '0;
    bus.instr  = '0;
    if (bus.out_valid) begin
      bus.set_pa[PAGE_EN_BIT] = switch;
      bus.set_pa[1:0]         = switch ? head_page : 2'b00;
      bus.instr               = head[1:0];
    end
  end

  // A beat accepted in a flush cycle is discarded, so it must not update
  // the tracked header either.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_q     <= '0;
      hdr_known <= 1'b0;
    end else if (flush) begin
      hdr_known <= 1'b0;
    end else if (fire && switch) begin
      hdr_q     <= head_page;
      hdr_known <= 1'b1;
    end
  end

`ifdef REGENC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      page_switches <= '0;
    end else if (fire && switch && (page_switches != 16'hFFFF)) begin
      page_switches <= page_switches + 16'd1;
    end
  end
`endif
endmodule
